// File: rtl/ram_loader.sv
// ram_loader: takes a counted byte stream from the host, buffers it in a
// small FIFO and replays it as registered write strobes into a datapath RAM.
// Loads run IDLE -> LOAD -> DONE; abort or reset cancels a load and drops
// anything still buffered.
module ram_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH:0]   load_len,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  wr_hold,
  output logic                  ram_write_en,
  output logic [DATA_WIDTH-1:0] ram_write_data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   wr_count
);

  // FIFO index width; the pointers carry one extra wrap bit for full/empty.
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PW:0]         PTR_ONE  = {{PW{1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_acc_cnt;
  logic [ADDR_WIDTH:0]   r_wr_cnt;
  logic [PW:0]           r_wptr;
  logic [PW:0]           r_rptr;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic                  w_load;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH:0]   w_wr_inc;
  logic [DATA_WIDTH-1:0] w_head;

  assign w_load   = (r_state == S_LOAD);
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[PW] != r_rptr[PW]) &&
                    (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  // Ready depends only on registered state, so a pop in a full cycle
  // cannot open the door for a push in the same cycle.
  assign s_ready  = w_load && !w_full && (r_acc_cnt < r_len);
  assign w_push   = s_valid && s_ready;
  // Abort beats a write that would otherwise issue this edge.
  assign w_pop    = w_load && !abort && !w_empty && !wr_hold;
  assign w_wr_inc = r_wr_cnt + CNT_ONE;
  assign w_head   = r_mem[r_rptr[PW-1:0]];

  assign busy           = w_load;
  assign done           = (r_state == S_DONE);
  assign ram_write_en   = r_wen;
  assign ram_write_data = r_wdata;
  assign wr_count       = r_wr_cnt;

  // FIFO storage: plain registers, contents are meaningless once flushed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[PW-1:0]] <= s_data;
  end

  // Control FSM, counters, FIFO pointers and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_len     <= CNT_ZERO;
      r_acc_cnt <= CNT_ZERO;
      r_wr_cnt  <= CNT_ZERO;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len     <= load_len;
            r_acc_cnt <= CNT_ZERO;
            r_wr_cnt  <= CNT_ZERO;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_state   <= (load_len == CNT_ZERO) ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            // wr_count keeps the partial progress for the host to read.
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_state <= S_IDLE;
          end else begin
            if (w_push) begin
              r_wptr    <= r_wptr + PTR_ONE;
              r_acc_cnt <= r_acc_cnt + CNT_ONE;
            end
            if (w_pop) begin
              r_rptr  <= r_rptr + PTR_ONE;
              r_wen   <= 1'b1;
              r_wdata <= w_head;
              if (r_wr_cnt < r_len) r_wr_cnt <= w_wr_inc;
              // Final write lands in the same cycle as the done pulse.
              if (w_wr_inc == r_len) r_state <= S_DONE;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: a byte source fed from a queue, a write
// monitor sampling on the falling edge, and hand-computed expectations.
module tb_ram_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [11:0] load_len;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        wr_hold;
  logic        ram_write_en;
  logic [7:0]  ram_write_data;
  logic        busy;
  logic        done;
  logic [11:0] wr_count;

  ram_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .load_len       (load_len),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .wr_hold        (wr_hold),
    .ram_write_en   (ram_write_en),
    .ram_write_data (ram_write_data),
    .busy           (busy),
    .done           (done),
    .wr_count       (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] src_q[$];
  logic [7:0] wr_q[$];
  int         wr_edge[$];
  int         cyc_n     = 0;
  int         n_done    = 0;
  int         n_rdy     = 0;
  int         n_acc     = 0;
  int         first_acc = -1;
  logic       done_wen  = 1'b0;
  logic [7:0] done_dat  = 8'h00;
  logic       feed_en   = 1'b0;
  logic       prev_acc  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] wr_at(input int i);
    if (i < wr_q.size()) return wr_q[i];
    return 8'hxx;
  endfunction

  function automatic int edge_span();
    if (wr_edge.size() == 0) return -1;
    return wr_edge[wr_edge.size()-1] - wr_edge[0];
  endfunction

  // Present the head of the source queue; handshake is judged on s_ready now,
  // which only changes at the next rising edge.
  task automatic refresh();
    s_valid  = feed_en && (src_q.size() > 0);
    s_data   = (src_q.size() > 0) ? src_q[0] : 8'h00;
    prev_acc = s_valid && s_ready;
  endtask

  task automatic clear_log();
    wr_q.delete();
    wr_edge.delete();
    n_done    = 0;
    n_rdy     = 0;
    n_acc     = 0;
    first_acc = -1;
    done_wen  = 1'b0;
    done_dat  = 8'h00;
  endtask

  // One cycle: wait for the falling edge, log outputs, advance the source.
  task automatic tick();
    @(negedge clk);
    cyc_n++;
    if (ram_write_en) begin
      wr_q.push_back(ram_write_data);
      wr_edge.push_back(cyc_n);
    end
    if (done) begin
      n_done++;
      done_wen = ram_write_en;
      done_dat = ram_write_data;
    end
    if (s_ready) n_rdy++;
    if (prev_acc) begin
      void'(src_q.pop_front());
      n_acc++;
      if (first_acc < 0) first_acc = cyc_n;
    end
    refresh();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic kick(input logic [11:0] len);
    load_len = len;
    start    = 1'b1;
    refresh();
    tick();
    start    = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    abort    = 1'b0;
    load_len = '0;
    wr_hold  = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;

    // Reset state
    ticks(3);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
    chk("rst_wen", {31'd0, ram_write_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wdata", {24'd0, ram_write_data}, 32'd0);
    chk("rst_wr_count", {20'd0, wr_count}, 32'd0);
    #1 rst_n = 1'b1;

    // Idle with s_valid high: nothing accepted
    clear_log();
    feed_en = 1'b1;
    src_q   = '{8'hEE};
    refresh();
    ticks(10);
    chk("idle_ready_cycles", n_rdy, 0);
    chk("idle_accepts", n_acc, 0);
    chk("idle_writes", wr_q.size(), 0);

    // len=3 streaming; a fourth byte stays unconsumed
    clear_log();
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    kick(12'd3);
    ticks(11);
    chk("l3_nwr", wr_q.size(), 3);
    chk("l3_d0", {24'd0, wr_at(0)}, 32'h11);
    chk("l3_d1", {24'd0, wr_at(1)}, 32'h22);
    chk("l3_d2", {24'd0, wr_at(2)}, 32'h33);
    chk("l3_consec", edge_span(), 2);
    chk("l3_latency", (wr_edge.size() > 0) ? wr_edge[0] - first_acc : -1, 1);
    chk("l3_ndone", n_done, 1);
    chk("l3_done_wen", {31'd0, done_wen}, 32'd1);
    chk("l3_done_dat", {24'd0, done_dat}, 32'h33);
    chk("l3_wr_count", {20'd0, wr_count}, 32'd3);
    chk("l3_left", src_q.size(), 1);
    chk("l3_busy", {31'd0, busy}, 32'd0);

    // len=8 under back-pressure: FIFO fills to 4 then stalls
    clear_log();
    wr_hold = 1'b1;
    src_q   = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    kick(12'd8);
    ticks(5);
    chk("bp_accepts", n_acc, 4);
    chk("bp_nowrite", wr_q.size(), 0);
    chk("bp_ready", {31'd0, s_ready}, 32'd0);
    chk("bp_busy", {31'd0, busy}, 32'd1);
    wr_hold = 1'b0;
    ticks(20);
    chk("bp_nwr", wr_q.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("bp_d%0d", i), {24'd0, wr_at(i)}, i + 1);
    chk("bp_consec", edge_span(), 7);
    chk("bp_ndone", n_done, 1);
    chk("bp_done_dat", {24'd0, done_dat}, 32'h08);
    chk("bp_wr_count", {20'd0, wr_count}, 32'd8);

    // len=0: immediate one-cycle done, no writes
    clear_log();
    src_q.delete();
    kick(12'd0);
    chk("z_done", {31'd0, done}, 32'd1);
    chk("z_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("z_done_drop", {31'd0, done}, 32'd0);
    ticks(3);
    chk("z_ndone", n_done, 1);
    chk("z_nwr", wr_q.size(), 0);
    chk("z_wr_count", {20'd0, wr_count}, 32'd0);

    // len=5 aborted after two writes
    clear_log();
    src_q = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h55};
    kick(12'd5);
    for (int i = 0; i < 20 && wr_q.size() < 2; i++) tick();
    chk("ab_reach2", wr_q.size(), 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ticks(5);
    chk("ab_nwr", wr_q.size(), 2);
    chk("ab_d1", {24'd0, wr_at(1)}, 32'h52);
    chk("ab_ndone", n_done, 0);
    chk("ab_wr_count", {20'd0, wr_count}, 32'd2);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    clear_log();
    src_q = '{8'hA0, 8'hA1};
    kick(12'd2);
    ticks(10);
    chk("ab2_nwr", wr_q.size(), 2);
    chk("ab2_d0", {24'd0, wr_at(0)}, 32'hA0);
    chk("ab2_d1", {24'd0, wr_at(1)}, 32'hA1);
    chk("ab2_ndone", n_done, 1);
    chk("ab2_wr_count", {20'd0, wr_count}, 32'd2);

    // Reset pulse mid-load with three bytes still buffered
    clear_log();
    wr_hold = 1'b1;
    src_q   = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
    kick(12'd8);
    ticks(5);
    wr_hold = 1'b0;
    tick();
    chk("mr_wen_before", {31'd0, ram_write_en}, 32'd1);
    chk("mr_dat_before", {24'd0, ram_write_data}, 32'hC1);
    rst_n = 1'b0;
    #1;
    chk("mr_wen_drop", {31'd0, ram_write_en}, 32'd0);
    chk("mr_busy_drop", {31'd0, busy}, 32'd0);
    src_q.delete();
    refresh();
    ticks(2);
    rst_n = 1'b1;
    clear_log();
    ticks(10);
    chk("mr_no_stale", wr_q.size(), 0);
    chk("mr_wr_count", {20'd0, wr_count}, 32'd0);
    src_q = '{8'hD1};
    kick(12'd1);
    ticks(8);
    chk("mr_nwr", wr_q.size(), 1);
    chk("mr_d0", {24'd0, wr_at(0)}, 32'hD1);
    chk("mr_ndone", n_done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the byte width of the stream and RAM write data.
REQ-002 Parameter ADDR_WIDTH, default 11, SHALL set the RAM address width; the length and count ports are ADDR_WIDTH+1 bits wide.
REQ-003 Parameter FIFO_DEPTH, default 4 (power of 2), SHALL set the number of internal buffer entries.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
REQ-007 abort  in  1  synchronous cancel of the current load.
REQ-008 load_len  in  ADDR_WIDTH+1  number of bytes to load; latched on an accepted start.
REQ-009 s_valid  in  1  host byte valid.
REQ-010 s_data  in  DATA_WIDTH  host byte.
REQ-011 s_ready  out  1  loader accepts the byte this cycle.
REQ-012 wr_hold  in  1  datapath back-pressure; when high, no RAM write is issued.
REQ-013 ram_write_en  out  1  registered write strobe to the datapath RAM write port.
REQ-014 ram_write_data  out  DATA_WIDTH  registered write byte, valid when ram_write_en=1.
REQ-015 busy  out  1  high in LOAD.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 wr_count  out  ADDR_WIDTH+1  number of bytes written in the current or last load.

Function
REQ-018 States SHALL be IDLE, LOAD and DONE; the encoding is free.
REQ-019 In IDLE, start=1 with load_len>0 SHALL move to LOAD, latch load_len, clear wr_count, the accept count and the FIFO.
REQ-020 In IDLE, start=1 with load_len=0 SHALL move to DONE with no writes and wr_count=0.
REQ-021 start SHALL be ignored in LOAD and DONE.
REQ-022 s_ready SHALL be 1 only in LOAD while the FIFO is not full and accept_count<len; it is a function of registered state only and does not depend on s_valid.
REQ-023 A byte is accepted at an edge with s_valid=1 and s_ready=1; it is pushed into the FIFO in order.
REQ-024 When the FIFO is full and a pop occurs in the same cycle, s_ready SHALL still be 0 in that cycle.
REQ-025 At each edge in LOAD with the FIFO not empty and wr_hold=0, the loader SHALL pop the head and register ram_write_en=1 and ram_write_data=head; otherwise ram_write_en<=0 and ram_write_data holds its value.
REQ-026 Latency: a byte accepted at edge k into an empty FIFO with wr_hold=0 SHALL appear on ram_write_data, with ram_write_en=1, in the cycle after edge k+1.
REQ-027 A push and a pop SHALL be allowed in the same cycle; the occupancy is then unchanged.
REQ-028 wr_count SHALL increment once per issued write and saturates at len.
REQ-029 The edge that issues the write making wr_count equal len SHALL move to DONE, so done=1 coincides with the final ram_write_en=1 cycle.
REQ-030 DONE SHALL last exactly one cycle and then return to IDLE; ram_write_en<=0 on leaving DONE.
REQ-031 abort=1 in LOAD SHALL, at the next edge, go to IDLE, flush the FIFO and force ram_write_en<=0, with no done pulse; wr_count holds its value; abort SHALL be ignored in other states.
REQ-032 If abort and a write-issue condition coincide, abort SHALL win and no write is issued.
REQ-033 s_valid or s_data outside LOAD SHALL have no effect.

Reset
REQ-034 While rst_n=0, the state SHALL be IDLE and s_ready, ram_write_en, busy and done SHALL be 0; ram_write_data, wr_count, the counts and the FIFO pointers SHALL be 0.
REQ-035 Asserting reset mid-load SHALL discard all buffered data; after release the block waits for a new start.

Verification
REQ-036 Apply reset, then release with start=0 -> all outputs 0, and s_ready=0 for 10 cycles despite s_valid=1.
REQ-037 len=3, s_valid held high with bytes 0x11,0x22,0x33, wr_hold=0 -> ram_write_en high for 3 consecutive cycles with data 0x11,0x22,0x33, done on the 3rd cycle, wr_count=3, s_ready low after the 3rd accept.
REQ-038 len=8, wr_hold=1 for 6 cycles, s_valid high -> 4 accepts, then s_ready=0 and no writes; release wr_hold -> back-to-back writes in order, with all 8 bytes written and then done.
REQ-039 start with len=0 -> done=1 for one cycle on the cycle after start, ram_write_en never high, wr_count=0.
REQ-040 len=5, abort after 2 writes -> IDLE with no done, wr_count=2; then start len=2 with bytes 0xA0,0xA1 -> only 0xA0,0xA1 written, and done.
REQ-041 rst_n pulsed low mid-load with 3 bytes buffered -> ram_write_en drops immediately; after release no stale byte is ever written.
